// File: rtl/iter_alu.sv
// Registered ALU for the multicycle datapath: single-cycle RV32I ops plus
// iterative MUL/MULHU/DIVU/REMU behind a start/busy/done handshake.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             Zero,
    output logic             SignBit
);
    // state | meaning
    // IDLE  | accepting starts; simple ops complete here in one edge
    // RUN   | iterating multiply/divide, one bit per cycle

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               hi_q, hi_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   simple_res;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    assign shamt = b[SHW-1:0];

    always_comb begin
        simple_res = '0;
        case (op)
            4'd0: simple_res = a + b;
            4'd1: simple_res = a - b;
            4'd2: simple_res = a & b;
            4'd3: simple_res = a | b;
            4'd4: simple_res = a ^ b;
            4'd5: simple_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd6: simple_res = {{(WIDTH-1){1'b0}}, a < b};
            4'd7: simple_res = a << shamt;
            4'd8: simple_res = a >> shamt;
            4'd9: simple_res = $signed(a) >>> shamt;
            default: simple_res = '0;
        endcase
    end

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits becoming quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        step_next = div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        hi_d     = hi_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op inside {4'd10, 4'd11, 4'd12, 4'd13}) begin
                        state_d = RUN;
                        cnt_d   = CNT_INIT;
                        div_d   = op[2];
                        hi_d    = op[0];
                        opnd_d  = op[2] ? b : a;
                        acc_d   = {{WIDTH{1'b0}}, (op[2] ? a : b)};
                    end else begin
                        result_d = simple_res;
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = step_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    result_d = hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result  = result_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign Zero    = (result_q == '0);
    assign SignBit = result_q[WIDTH-1];

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: 32-bit instance for the full op set and
// handshake, 8-bit instance for the narrow multiply case.
module tb_iter_alu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [3:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done, Zero, SignBit;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        busy8, done8, Zero8, SignBit8;

    int checks = 0;
    int failures = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .Zero(Zero), .SignBit(SignBit)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(result8), .busy(busy8), .done(done8), .Zero(Zero8), .SignBit(SignBit8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic simple(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input string tag);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " result"}, result, exp);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " flags"}, {Zero, SignBit}, {exp == 32'h0, exp[31]});
    endtask

    task automatic iter(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag, input bit toggle, input bit hold);
        int n;
        bit held_ok;
        logic [31:0] prev;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        prev = result;
        n = 0;
        held_ok = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (done !== 1'b0 || result !== prev) held_ok = 1'b0;
            if (toggle) begin a = $urandom; b = $urandom; end
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, n, 32);
        chk({tag, " done"}, done, 1);
        chk({tag, " result"}, result, exp);
        chk({tag, " flags"}, {Zero, SignBit}, {exp == 32'h0, exp[31]});
        chk({tag, " stable during run"}, held_ok, 1);
    endtask

    task automatic iter8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp, input string tag);
        int n;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, n, 8);
        chk({tag, " done"}, done8, 1);
        chk({tag, " result"}, result8, exp);
        chk({tag, " flags"}, {Zero8, SignBit8}, {exp == 8'h0, exp[7]});
    endtask

    initial begin
        start8 = 1'b0; op8 = 4'd0; a8 = 8'h0; b8 = 8'h0;

        // reset with a start pending
        rst = 1'b1; start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset result", result, 0);
            chk("reset Zero", Zero, 1);
            chk("reset busy", busy, 0);
            chk("reset done", done, 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post-reset result", result, 0);
        chk("post-reset done", done, 0);
        chk("post-reset busy8", busy8, 0);

        simple(4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, "ADD ovf");
        simple(4'd1,  32'd5,         32'd5,         32'h0,         "SUB zero");
        simple(4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, "AND");
        simple(4'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, "OR");
        simple(4'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, "XOR");
        simple(4'd5,  32'hFFFF_FFFF, 32'h1,         32'h1,         "SLT");
        simple(4'd6,  32'hFFFF_FFFF, 32'h1,         32'h0,         "SLTU");
        simple(4'd7,  32'h1,         32'd33,        32'h2,         "SLL 33");
        simple(4'd8,  32'h8000_0000, 32'd4,         32'h0800_0000, "SRL");
        simple(4'd9,  32'h8000_0000, 32'd4,         32'hF800_0000, "SRA");
        simple(4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, "SUB neg");
        simple(4'd14, 32'd5,         32'd3,         32'h0,         "reserved14");
        simple(4'd0,  32'd9,         32'd1,         32'd10,        "ADD");
        @(negedge clk);
        chk("done single pulse", done, 0);
        chk("result holds", result, 10);

        iter(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL", 1'b1, 1'b0);
        iter(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU", 1'b1, 1'b0);
        iter(4'd12, 32'd100,       32'd7,         32'd14,        "DIVU", 1'b1, 1'b0);
        iter(4'd13, 32'd100,       32'd7,         32'd2,         "REMU", 1'b0, 1'b0);
        iter(4'd12, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, "DIVU by1", 1'b0, 1'b0);
        iter(4'd12, 32'h1234,      32'h0,         32'hFFFF_FFFF, "DIVU by0", 1'b0, 1'b0);
        iter(4'd13, 32'h1234,      32'h0,         32'h1234,      "REMU by0", 1'b0, 1'b0);
        iter(4'd12, 32'h8000_0001, 32'h0,         32'hFFFF_FFFF, "DIVU msb by0", 1'b0, 1'b0);

        // start held through a MUL, then an ADD accepted on the done cycle
        iter(4'd10, 32'd3, 32'd5, 32'd15, "MUL held start", 1'b0, 1'b1);
        op = 4'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b ADD done", done, 1);
        chk("b2b ADD result", result, 7);
        chk("b2b ADD busy", busy, 0);
        @(negedge clk);
        chk("b2b done ends", done, 0);
        chk("b2b result holds", result, 7);

        // reset in the middle of a divide
        op = 4'd12; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midop busy before rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop rst busy", busy, 0);
        chk("midop rst done", done, 0);
        chk("midop rst result", result, 0);
        chk("midop rst Zero", Zero, 1);
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) break;
        end
        chk("midop no late done", {busy, done}, 0);
        simple(4'd0, 32'd2, 32'd2, 32'd4, "ADD after rst");
        iter(4'd13, 32'd100, 32'd7, 32'd2, "REMU after rst", 1'b0, 1'b0);

        iter8(4'd10, 8'hFF, 8'hFF, 8'h01, "W8 MUL");
        iter8(4'd11, 8'hFF, 8'hFF, 8'hFE, "W8 MULHU");
        iter8(4'd12, 8'd200, 8'd9, 8'd22, "W8 DIVU");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
